// File: rtl/sorter_pkg.sv
// Shared definitions for the sorter read path: register map, response codes,
// read-FSM states and the decoded register selector.
package sorter_pkg;

  // Register map (full 32-bit address compare)
  localparam logic [31:0] ADDR_POP_VAL   = 32'h0000_0008;
  localparam logic [31:0] ADDR_POP_IVAL  = 32'h0000_000C;
  localparam logic [31:0] ADDR_VAL_CTR   = 32'h0000_0010;
  localparam logic [31:0] ADDR_IVAL_CTR  = 32'h0000_0014;
  localparam logic [31:0] ADDR_FLAGS     = 32'h0000_0018;

  // Read response codes
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } rresp_e;

  // Read transaction FSM
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Which status register a read address selects
  typedef enum logic [1:0] {
    REG_NONE     = 2'd0,
    REG_VAL_CTR  = 2'd1,
    REG_IVAL_CTR = 2'd2,
    REG_FLAGS    = 2'd3
  } reg_sel_e;

endpackage : sorter_pkg

// File: rtl/axi_lite_sorter_reader_if.sv
// AXI-Lite read channel (AR + R) between a bus master and the sorter reader.
interface axi_lite_sorter_reader_if #(
  parameter int WIDTH = 32
);
  logic             ARVALID;
  logic [31:0]      ARADDR;
  logic             ARREADY;
  logic             RVALID;
  logic             RREADY;
  logic [WIDTH-1:0] RDATA;
  logic [1:0]       RRESP;

  modport master (
    output ARVALID, ARADDR, RREADY,
    input  ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  ARVALID, ARADDR, RREADY,
    output ARREADY, RVALID, RDATA, RRESP
  );
endinterface : axi_lite_sorter_reader_if

// File: rtl/sorter_rd_decode.sv
// Combinational read-address decoder: classifies ARADDR as a FIFO pop,
// a status-register read, or an unmapped address.
module sorter_rd_decode
  import sorter_pkg::*;
(
  input  logic [31:0] araddr,
  output logic        pop_val,
  output logic        pop_ival,
  output reg_sel_e    reg_sel,
  output logic        decerr
);

  // Exact-match address decode
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    pop_val  = 1'b0;
    pop_ival = 1'b0;
    reg_sel  = REG_NONE;
    decerr   = 1'b0;
    case (araddr)
      ADDR_POP_VAL:  pop_val  = 1'b1;
      ADDR_POP_IVAL: pop_ival = 1'b1;
      ADDR_VAL_CTR:  reg_sel  = REG_VAL_CTR;
      ADDR_IVAL_CTR: reg_sel  = REG_IVAL_CTR;
      ADDR_FLAGS:    reg_sel  = REG_FLAGS;
      default:       decerr   = 1'b1;
    endcase
  end

endmodule : sorter_rd_decode

// File: rtl/axi_lite_sorter_reader.sv
// AXI-Lite read slave for the sorter: pops the val/ival FIFOs or returns
// their occupancy/flags. One transaction in flight; all outputs registered.
module axi_lite_sorter_reader
  import sorter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  axi_lite_sorter_reader_if.slave      axi,
  output logic                         val_rd_en,
  output logic                         ival_rd_en,
  input  logic [WIDTH-1:0]             val_rd_data,
  input  logic [WIDTH-1:0]             ival_rd_data,
  input  logic                         val_empty,
  input  logic                         val_full,
  input  logic                         ival_empty,
  input  logic                         ival_full,
  input  logic [DEPTH-1:0]             val_fifo_ctr,
  input  logic [DEPTH-1:0]             ival_fifo_ctr
);

  logic       dec_pop_val;
  logic       dec_pop_ival;
  reg_sel_e   dec_reg_sel;
  logic       dec_decerr;

  logic [WIDTH-1:0] reg_val;

  state_e           state_q, state_d;
  logic             arready_q, arready_d;
  logic             rvalid_q, rvalid_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  rresp_e           rresp_q, rresp_d;
  logic             val_rd_en_q, val_rd_en_d;
  logic             ival_rd_en_q, ival_rd_en_d;
  logic             sel_ival_q, sel_ival_d;   // FIFO whose data is captured in WAIT

  sorter_rd_decode u_decode (
    .araddr   (axi.ARADDR),
    .pop_val  (dec_pop_val),
    .pop_ival (dec_pop_ival),
    .reg_sel  (dec_reg_sel),
    .decerr   (dec_decerr)
  );

  // Status register value as seen at the AR handshake edge
  always_comb begin
    reg_val = '0;
    case (dec_reg_sel)
      REG_VAL_CTR:  reg_val = WIDTH'(val_fifo_ctr);
      REG_IVAL_CTR: reg_val = WIDTH'(ival_fifo_ctr);
      REG_FLAGS:    reg_val = WIDTH'({ival_full, ival_empty, val_full, val_empty});
      default:      reg_val = '0;
    endcase
  end

  // Next-state and next-output logic of the read FSM
  always_comb begin
    state_d      = state_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    sel_ival_d   = sel_ival_q;
    val_rd_en_d  = 1'b0;
    ival_rd_en_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (axi.ARVALID && arready_q) begin
          if (dec_pop_val) begin
            if (!val_empty) begin
              val_rd_en_d = 1'b1;
              sel_ival_d  = 1'b0;
              state_d     = ST_POP;
            end else begin
              rdata_d = '0;
              rresp_d = RESP_SLVERR;
              state_d = ST_RESP;
            end
          end else if (dec_pop_ival) begin
            if (!ival_empty) begin
              ival_rd_en_d = 1'b1;
              sel_ival_d   = 1'b1;
              state_d      = ST_POP;
            end else begin
              rdata_d = '0;
              rresp_d = RESP_SLVERR;
              state_d = ST_RESP;
            end
          end else if (dec_decerr) begin
            rdata_d = '0;
            rresp_d = RESP_DECERR;
            state_d = ST_RESP;
          end else begin
            rdata_d = reg_val;
            rresp_d = RESP_OKAY;
            state_d = ST_RESP;
          end
        end
      end
      // rd_en is high during POP; the FIFO presents data during WAIT
      ST_POP:  state_d = ST_WAIT;
      ST_WAIT: begin
        rdata_d = sel_ival_q ? ival_rd_data : val_rd_data;
        rresp_d = RESP_OKAY;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (axi.RREADY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    arready_d = (state_d == ST_IDLE);
    rvalid_d  = (state_d == ST_RESP);
  end

  // State and output registers; reset drops any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      rresp_q      <= RESP_OKAY;
      val_rd_en_q  <= 1'b0;
      ival_rd_en_q <= 1'b0;
      sel_ival_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q      <= state_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      val_rd_en_q  <= val_rd_en_d;
      ival_rd_en_q <= ival_rd_en_d;
      sel_ival_q   <= sel_ival_d;
    end
  end

  assign axi.ARREADY = arready_q;
  assign axi.RVALID  = rvalid_q;
  assign axi.RDATA   = rdata_q;
  assign axi.RRESP   = rresp_q;
  assign val_rd_en   = val_rd_en_q;
  assign ival_rd_en  = ival_rd_en_q;

endmodule : axi_lite_sorter_reader

// File: tb/tb_axi_lite_sorter_reader.sv
// Self-checking bench for axi_lite_sorter_reader: directed register-map and
// handshake cases followed by randomized reads against a reference model.
module tb_axi_lite_sorter_reader;

  localparam int WIDTH = 32;
  localparam int DEPTH = 10;

  logic             clk;
  logic             rst;
  logic             val_rd_en, ival_rd_en;
  logic [WIDTH-1:0] val_rd_data, ival_rd_data;
  logic             val_empty, val_full, ival_empty, ival_full;
  logic [DEPTH-1:0] val_fifo_ctr, ival_fifo_ctr;

  axi_lite_sorter_reader_if #(.WIDTH(WIDTH)) axi ();

  axi_lite_sorter_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .axi           (axi),
    .val_rd_en     (val_rd_en),
    .ival_rd_en    (ival_rd_en),
    .val_rd_data   (val_rd_data),
    .ival_rd_data  (ival_rd_data),
    .val_empty     (val_empty),
    .val_full      (val_full),
    .ival_empty    (ival_empty),
    .ival_full     (ival_full),
    .val_fifo_ctr  (val_fifo_ctr),
    .ival_fifo_ctr (ival_fifo_ctr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stub FIFOs: stub queues feed rd_data; model queues track what should come out.
  logic [31:0] val_src_q[$];
  logic [31:0] ival_src_q[$];
  logic [31:0] val_exp_q[$];
  logic [31:0] ival_exp_q[$];
  int val_pulses  = 0;
  int ival_pulses = 0;
  int both_high   = 0;

  initial begin
    val_rd_data  = '0;
    ival_rd_data = '0;
  end

  always @(posedge clk) begin
    if (val_rd_en) begin
      val_pulses++;
      if (val_src_q.size() != 0) val_rd_data <= val_src_q.pop_front();
      else                       val_rd_data <= 32'hDEAD_BEEF;
    end
    if (ival_rd_en) begin
      ival_pulses++;
      if (ival_src_q.size() != 0) ival_rd_data <= ival_src_q.pop_front();
      else                        ival_rd_data <= 32'hDEAD_BEEF;
    end
    if (val_rd_en && ival_rd_en) both_high++;
  end

  task automatic push_val(input logic [31:0] d);
    val_src_q.push_back(d);
    val_exp_q.push_back(d);
  endtask

  task automatic push_ival(input logic [31:0] d);
    ival_src_q.push_back(d);
    ival_exp_q.push_back(d);
  endtask

  task automatic top_up();
    while (val_exp_q.size() < 2)  push_val($urandom);
    while (ival_exp_q.size() < 2) push_ival($urandom);
  endtask

  task automatic random_flags();
    val_empty     = 1'($urandom_range(0, 1));
    val_full      = 1'($urandom_range(0, 1));
    ival_empty    = 1'($urandom_range(0, 1));
    ival_full     = 1'($urandom_range(0, 1));
    val_fifo_ctr  = DEPTH'($urandom_range(0, 1023));
    ival_fifo_ctr = DEPTH'($urandom_range(0, 1023));
  endtask

  // Reference model: what a read of addr returns given the inputs at the AR handshake.
  task automatic model(input logic [31:0] addr, output logic [31:0] rdata,
                       output logic [1:0] rresp, output int lat,
                       output int vpops, output int ipops);
    rdata = 32'h0; rresp = 2'b00; lat = 1; vpops = 0; ipops = 0;
    if (addr == 32'h08) begin
      if (!val_empty) begin rdata = val_exp_q.pop_front(); lat = 3; vpops = 1; end
      else rresp = 2'b10;
    end else if (addr == 32'h0C) begin
      if (!ival_empty) begin rdata = ival_exp_q.pop_front(); lat = 3; ipops = 1; end
      else rresp = 2'b10;
    end else if (addr == 32'h10) rdata = 32'(val_fifo_ctr);
    else if (addr == 32'h14)     rdata = 32'(ival_fifo_ctr);
    else if (addr == 32'h18)     rdata = {28'b0, ival_full, ival_empty, val_full, val_empty};
    else                         rresp = 2'b11;
  endtask

  // One complete read; called and returns at a falling edge.
  task automatic do_read(input logic [31:0] addr, input int stall, input bit scramble);
    logic [31:0] e_data;
    logic [1:0]  e_resp;
    int e_lat, e_vp, e_ip, v0, i0, lat, waited;
    axi.RREADY  = 1'b0;
    axi.ARVALID = 1'b1;
    axi.ARADDR  = addr;
    waited = 0;
    while (!axi.ARREADY && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!axi.ARREADY) begin
      check("arready_timeout", 32'(axi.ARREADY), 32'h1);
      axi.ARVALID = 1'b0;
      return;
    end
    model(addr, e_data, e_resp, e_lat, e_vp, e_ip);
    v0 = val_pulses;
    i0 = ival_pulses;
    @(posedge clk);  // AR handshake edge
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      axi.ARVALID = 1'b0;
      if (scramble) random_flags();
    end while (!axi.RVALID && lat < 8);
    check("rvalid_latency", 32'(lat), 32'(e_lat));
    check("rdata", axi.RDATA, e_data);
    check("rresp", 32'(axi.RRESP), 32'(e_resp));
    check("arready_in_resp", 32'(axi.ARREADY), 32'h0);
    for (int i = 0; i < stall; i++) begin
      axi.ARVALID = 1'b1;
      axi.ARADDR  = 32'h10;
      @(negedge clk);
      check("stall_rvalid", 32'(axi.RVALID), 32'h1);
      check("stall_rdata", axi.RDATA, e_data);
      check("stall_rresp", 32'(axi.RRESP), 32'(e_resp));
      check("stall_arready", 32'(axi.ARREADY), 32'h0);
    end
    axi.ARVALID = 1'b0;
    axi.RREADY  = 1'b1;
    @(negedge clk);
    axi.RREADY  = 1'b0;
    check("rvalid_after_hs", 32'(axi.RVALID), 32'h0);
    check("arready_after_hs", 32'(axi.ARREADY), 32'h1);
    check("val_pops", 32'(val_pulses - v0), 32'(e_vp));
    check("ival_pops", 32'(ival_pulses - i0), 32'(e_ip));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arready"}, 32'(axi.ARREADY), 32'h0);
    check({tag, "_rvalid"},  32'(axi.RVALID), 32'h0);
    check({tag, "_rdata"},   axi.RDATA, 32'h0);
    check({tag, "_rresp"},   32'(axi.RRESP), 32'h0);
    check({tag, "_val_rd_en"},  32'(val_rd_en), 32'h0);
    check({tag, "_ival_rd_en"}, 32'(ival_rd_en), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] addr;
    rst = 1'b1;
    axi.ARVALID = 1'b0;
    axi.ARADDR  = '0;
    axi.RREADY  = 1'b0;
    val_empty = 1'b1; val_full = 1'b0; ival_empty = 1'b1; ival_full = 1'b0;
    val_fifo_ctr = '0; ival_fifo_ctr = '0;

    // Reset state, and ARREADY rising only after release
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    #1;
    check("arready_at_release", 32'(axi.ARREADY), 32'h0);
    @(negedge clk);
    check("arready_after_release", 32'(axi.ARREADY), 32'h1);

    // Pop from a one-entry val FIFO
    push_val(32'hA500_0001);
    val_empty = 1'b0; val_fifo_ctr = DEPTH'(1);
    do_read(32'h08, 0, 1'b0);

    // Pop from an empty ival FIFO
    ival_empty = 1'b1;
    do_read(32'h0C, 0, 1'b0);

    // Occupancy and flag registers
    val_fifo_ctr = DEPTH'(3); ival_full = 1'b1; val_empty = 1'b0;
    ival_empty = 1'b0; val_full = 1'b0;
    do_read(32'h10, 0, 1'b0);
    do_read(32'h18, 0, 1'b0);
    ival_fifo_ctr = DEPTH'(1023);
    do_read(32'h14, 0, 1'b0);

    // Unmapped address
    do_read(32'h20, 0, 1'b0);

    // Backpressure on a successful ival pop
    top_up();
    do_read(32'h0C, 5, 1'b0);

    // Reset while the pop is in WAIT: popped entry is lost, next read gets the following one
    top_up();
    val_empty = 1'b0;
    axi.ARVALID = 1'b1;
    axi.ARADDR  = 32'h08;
    check("pre_wait_arready", 32'(axi.ARREADY), 32'h1);
    void'(val_exp_q.pop_front());
    @(posedge clk);
    @(negedge clk);
    axi.ARVALID = 1'b0;
    check("pop_cycle_val_rd_en", 32'(val_rd_en), 32'h1);
    @(negedge clk);
    check("wait_cycle_val_rd_en", 32'(val_rd_en), 32'h0);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_in_wait");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_read(32'h08, 0, 1'b0);

    // Randomized reads with inputs changing while transactions are in flight
    for (int n = 0; n < 60; n++) begin
      top_up();
      random_flags();
      case ($urandom_range(0, 7))
        0, 1:    addr = 32'h08;
        2, 3:    addr = 32'h0C;
        4:       addr = 32'h10;
        5:       addr = 32'h14;
        6:       addr = 32'h18;
        default: addr = $urandom_range(0, 1) ? $urandom : 32'h0000_0108;
      endcase
      do_read(addr, int'($urandom_range(0, 3)), 1'b1);
    end

    check("rd_en_never_both", 32'(both_high), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_axi_lite_sorter_reader

// File: doc/axi_lite_sorter_reader.md
AXI_LITE_SORTER_READER -- requirements
Module: axi_lite_sorter_reader

Interface
REQ-001 Parameter WIDTH, default 32, AXI data width and FIFO entry width.
REQ-002 Parameter DEPTH, default 10, FIFO counter width in bits; legal range 1..32.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ARVALID  input  1  read address valid.
REQ-006 ARADDR  input  32  read address.
REQ-007 ARREADY  output  1  read address ready.
REQ-008 RVALID  output  1  read data valid.
REQ-009 RREADY  input  1  read data ready from master.
REQ-010 RDATA  output  WIDTH  read data.
REQ-011 RRESP  output  2  read response (00 OKAY, 10 SLVERR, 11 DECERR).
REQ-012 val_rd_en / ival_rd_en  output  1 each  single-cycle pop strobe to the val / ival FIFO.
REQ-013 val_rd_data / ival_rd_data  input  WIDTH each  FIFO read data, valid the cycle after the strobe is sampled.
REQ-014 val_empty, val_full, ival_empty, ival_full  input  1 each  FIFO flags.
REQ-015 val_fifo_ctr / ival_fifo_ctr  input  DEPTH each  FIFO occupancy.

Function
REQ-016 Address map (full 32-bit compare): 0x08 pop val; 0x0C pop ival; 0x10 val_fifo_ctr zero-extended; 0x14 ival_fifo_ctr zero-extended; 0x18 flags {28'b0, ival_full, ival_empty, val_full, val_empty}.
REQ-017 FSM states: IDLE, POP, WAIT, RESP.
REQ-018 ARREADY = 1 only in IDLE and not in reset; AR handshake = ARVALID & ARREADY at a rising edge (E0).
REQ-019 At E0, pop address with target FIFO non-empty (empty sampled at E0): IDLE->POP.
REQ-020 POP: the matching rd_en is high for exactly this one cycle; POP->WAIT.
REQ-021 WAIT: at the next edge RDATA <= selected rd_data, RRESP <= 00; WAIT->RESP.
REQ-022 At E0, pop address with target FIFO empty: no rd_en; RDATA <= 0, RRESP <= 10; IDLE->RESP.
REQ-023 At E0, register address (0x10/0x14/0x18): RDATA <= register value sampled at E0, RRESP <= 00; IDLE->RESP.
REQ-024 At E0, any other address: RDATA <= 0, RRESP <= 11; IDLE->RESP.
REQ-025 RVALID = 1 exactly in RESP; RDATA and RRESP are held stable while RVALID & !RREADY.
REQ-026 RESP->IDLE on RVALID & RREADY; the next AR is accepted no earlier than the following edge.
REQ-027 Latency: register and error reads give RVALID 1 cycle after E0; pops give it 3 cycles after E0.
REQ-028 At most one rd_en pulse per accepted pop; val_rd_en and ival_rd_en are never high together.
REQ-029 Concurrent FIFO pushes by the write path do not affect a transaction already accepted.

Reset
REQ-030 rst high forces immediately: state IDLE, ARREADY 0, RVALID 0, RDATA 0, RRESP 00, val_rd_en 0, ival_rd_en 0.
REQ-031 Reset in POP/WAIT/RESP drops the transaction; data already popped is discarded.
REQ-032 ARREADY rises the first cycle after rst deasserts.

Structure
REQ-033 Shared package sorter_pkg holds address constants (0x08/0x0C/0x10/0x14/0x18), RRESP codes, and the FSM state typedef.
REQ-034 One sub-module, sorter_rd_decode, is purely combinational and maps ARADDR to {pop_val, pop_ival, reg_sel, decerr}.

Verification
REQ-035 Stub val FIFO holding 0xA5000001 with ctr=1; read 0x08 -> one val_rd_en pulse, RDATA=0xA5000001, RRESP=00, RVALID 3 cycles after E0.
REQ-036 ival_empty=1; read 0x0C -> no ival_rd_en, RDATA=0, RRESP=10, RVALID 1 cycle after E0.
REQ-037 val_fifo_ctr=3, ival_full=1, val_empty=0; read 0x10 -> RDATA=3; read 0x18 -> RDATA=0x8.
REQ-038 Read 0x20 -> RDATA=0, RRESP=11, no rd_en.
REQ-039 RREADY held low 5 cycles during RESP -> RVALID, RDATA and RRESP are stable, ARREADY=0 throughout, and a second ARVALID is not accepted until the cycle after the R handshake.
REQ-040 Assert rst in WAIT -> all outputs at reset values within the same cycle; a following read of 0x08 pops the next entry.
